// File: rtl/msg_framer.sv
// msg_framer: frames a length request plus a raw payload stream into a
// HEAD / DATA x len / TAIL beat stream for the message-tracking consumer.
//
// Optional feature: define MSG_FRAMER_CHKSUM_EN to build the XOR checksum
// register; TAIL then carries the XOR of the message payload. Without it
// the TAIL beat carries zero.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_valid  message request present
//   req_ready  request accepted when req_valid & req_ready
//   req_len    number of DATA beats in the message
//   in_valid   payload beat present
//   in_ready   payload beat consumed when in_valid & in_ready
//   in_data    payload beat
//   out_valid  framed beat present
//   out_ready  framed beat taken when out_valid & out_ready
//   out_head   beat is the message header (data = zero-extended length)
//   out_tail   beat is the message trailer (data = checksum or 0)
//   out_data   beat contents
//   msg_ip     high from HEAD through the TAIL handshake
module msg_framer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    output logic              msg_ip
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] tail_data;
    logic              req_acc;
    logic              data_xfer;
    logic              last_beat;

    assign req_acc   = req_valid & req_ready;
    // DATA is a pass-through, so a payload beat moves only when the
    // consumer takes it.
    assign data_xfer = (state == DATA) & in_valid & out_ready;
    assign last_beat = data_xfer & (count_q == (len_q - LEN_W'(1)));

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = HEAD;
            HEAD: if (out_ready) state_nxt = (len_q != '0) ? DATA : TAIL;
            DATA: if (last_beat) state_nxt = TAIL;
            // A request waiting during TAIL goes straight to HEAD.
            TAIL: if (out_ready) state_nxt = req_valid ? HEAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_head  = 1'b0;
        out_tail  = 1'b0;
        out_data  = '0;
        case (state)
            // Held low while reset is asserted so nothing is accepted
            // until the block is released.
            IDLE: req_ready = reset_n;
            HEAD: begin
                out_valid            = 1'b1;
                out_head             = 1'b1;
                out_data[LEN_W-1:0]  = len_q;
            end
            DATA: begin
                out_valid = in_valid;
                out_data  = in_data;
                in_ready  = out_ready;
            end
            TAIL: begin
                out_valid = 1'b1;
                out_tail  = 1'b1;
                out_data  = tail_data;
                req_ready = out_ready;
            end
            default: ;
        endcase
    end

    assign msg_ip = (state != IDLE);

    // ---------------------------------------------------------------
    // Length latch and beat counter
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            count_q <= '0;
        end else begin
            if (req_acc) begin
                len_q   <= req_len;
                count_q <= '0;
            end else if (data_xfer) begin
                count_q <= last_beat ? '0 : count_q + LEN_W'(1);
            end
        end
    end

`ifdef MSG_FRAMER_CHKSUM_EN
    logic [DATA_W-1:0] chk_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       chk_q <= '0;
        else if (req_acc)   chk_q <= '0;
        else if (data_xfer) chk_q <= chk_q ^ in_data;
    end

    assign tail_data = chk_q;
`else
    assign tail_data = '0;
`endif

endmodule

// File: tb/tb_msg_framer.sv
// Directed bench for msg_framer. A queue-based model holds the beat sequence
// each message must produce; a negedge monitor pops it on every handshake.
module tb_msg_framer;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [LEN_W-1:0]  req_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_head;
    logic              out_tail;
    logic [DATA_W-1:0] out_data;
    logic              msg_ip;

    msg_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_head(out_head), .out_tail(out_tail), .out_data(out_data),
        .msg_ip(msg_ip)
    );

    always #5 clock = ~clock;

`ifdef MSG_FRAMER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic       head;
        logic       tail;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      cur;
    int         total = 0;
    int         bad = 0;
    int         beats_seen = 0;
    logic [7:0] last_tail = '0;
    logic [7:0] pl [16];
    int         gp [16];
    int         b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL timeout_%s got=no-event exp=event", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 16; i++) begin
            pl[i] = '0;
            gp[i] = 0;
        end
    endtask

    // Model: HEAD carries the length, payload passes through, TAIL carries
    // the XOR of the payload when the checksum is built, else zero.
    task automatic push_msg(input int len);
        beat_t      b;
        logic [7:0] x;
        x = '0;
        b.head = 1'b1; b.tail = 1'b0; b.data = 8'(len);
        exp_q.push_back(b);
        for (int i = 0; i < len; i++) begin
            b.head = 1'b0; b.tail = 1'b0; b.data = pl[i];
            exp_q.push_back(b);
            x = x ^ pl[i];
        end
        b.head = 1'b0; b.tail = 1'b1; b.data = CHK ? x : 8'h00;
        exp_q.push_back(b);
    endtask

    task automatic do_req(input int len);
        logic acc;
        int   n;
        n = 0;
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        do begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        req_valid = 1'b0;
        if (!acc) timeout("req");
    endtask

    task automatic feed(input int len);
        logic acc;
        int   n;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b0;
            for (int g = 0; g < gp[i]; g++) begin
                @(negedge clock);
                if (i > 0) check("gap_no_valid", out_valid, 0);
                @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_data  = pl[i];
            n = 0;
            do begin
                @(negedge clock);
                acc = in_ready;
                @(posedge clock);
                #1;
                n++;
            end while (!acc && n < 200);
            if (!acc) timeout("payload");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic busy;
        int   n;
        n = 0;
        do begin
            @(negedge clock);
            busy = msg_ip;
            @(posedge clock);
            #1;
            n++;
        end while (busy && n < 200);
        if (busy) timeout("idle");
    endtask

    // Monitor: every handshake beat must be the next one the model expects.
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            check("msg_ip_with_valid", msg_ip, 1);
            check("head_tail_excl", out_head & out_tail, 0);
            if (out_ready) begin
                beats_seen++;
                if (out_tail) last_tail = out_data;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%0h exp=none", out_data);
                end else begin
                    cur = exp_q.pop_front();
                    check("beat_head", out_head, cur.head);
                    check("beat_tail", out_tail, cur.tail);
                    check("beat_data", out_data, cur.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        clear_stim();
        // ---- reset state ----
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_head_tail", {out_head, out_tail}, 0);
        check("rst_msg_ip", msg_ip, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_req_ready", req_ready, 0);
        reset_n = 1'b1;
        #1;
        check("rel_req_ready", req_ready, 1);
        tick();

        // ---- len=0: HEAD at t+1, TAIL at t+2, IDLE at t+3 ----
        clear_stim();
        push_msg(0);
        req_valid = 1'b1;
        req_len   = '0;
        tick();
        req_valid = 1'b0;
        check("l0_head", {out_valid, out_head, out_tail}, 3'b110);
        check("l0_head_data", out_data, 0);
        check("l0_head_ip", msg_ip, 1);
        check("l0_head_req_ready", req_ready, 0);
        tick();
        check("l0_tail", {out_valid, out_head, out_tail}, 3'b101);
        check("l0_tail_data", out_data, 0);
        tick();
        check("l0_idle_ip", msg_ip, 0);
        check("l0_idle_valid", out_valid, 0);
        check("l0_idle_req_ready", req_ready, 1);

        // ---- len=2 with a 2-cycle gap ----
        clear_stim();
        pl[0] = 8'hA5; pl[1] = 8'h0F; gp[1] = 2;
        b0 = beats_seen;
        push_msg(2);
        do_req(2);
        feed(2);
        wait_idle();
        check("l2_beats", beats_seen - b0, 4);
        check("l2_tail", last_tail, CHK ? 8'hAA : 8'h00);

        // ---- backpressure in HEAD and TAIL ----
        clear_stim();
        pl[0] = 8'h3C;
        b0 = beats_seen;
        push_msg(1);
        do_req(1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        repeat (4) begin
            @(negedge clock);
            check("bp_head", {out_valid, out_head, out_tail}, 3'b110);
            check("bp_head_data", out_data, 8'h01);
            check("bp_head_in_ready", in_ready, 0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("bp_tail", {out_valid, out_head, out_tail}, 3'b101);
            check("bp_tail_data", out_data, CHK ? 8'h3C : 8'h00);
            check("bp_tail_in_ready", in_ready, 0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        wait_idle();
        check("bp_beats", beats_seen - b0, 3);

        // ---- back-to-back ----
        clear_stim();
        pl[0] = 8'h55;
        push_msg(1);
        clear_stim();
        pl[0] = 8'h66;
        push_msg(1);
        pl[0] = 8'h55;
        do_req(1);
        feed(1);
        req_valid = 1'b1;
        req_len   = 4'd1;
        @(negedge clock);
        check("b2b_tail", out_tail, 1);
        check("b2b_req_ready", req_ready, 1);
        check("b2b_tail_ip", msg_ip, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("b2b_head", out_head, 1);
        check("b2b_head_data", out_data, 8'h01);
        check("b2b_head_ip", msg_ip, 1);
        pl[0] = 8'h66;
        feed(1);
        wait_idle();
        check("b2b_tail2", last_tail, CHK ? 8'h66 : 8'h00);

        // ---- max length ----
        clear_stim();
        for (int i = 0; i < 15; i++) pl[i] = 8'(i + 1);
        b0 = beats_seen;
        push_msg(15);
        do_req(15);
        feed(15);
        wait_idle();
        check("max_beats", beats_seen - b0, 17);
        check("max_tail", last_tail, 8'h00);

        // ---- reset mid-DATA, then a clean message ----
        clear_stim();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_msg(3);
        do_req(3);
        feed(1);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clock);
            check("mrst_outs", {out_valid, out_head, out_tail, msg_ip, in_ready, req_ready}, 0);
            check("mrst_data", out_data, 0);
            @(posedge clock);
        end
        #1;
        reset_n = 1'b1;
        #1;
        check("mrst_rel_req_ready", req_ready, 1);
        check("mrst_rel_ip", msg_ip, 0);
        tick();
        clear_stim();
        pl[0] = 8'hF0; pl[1] = 8'h0F;
        push_msg(2);
        do_req(2);
        feed(2);
        wait_idle();
        check("mrst_clean_tail", last_tail, CHK ? 8'hFF : 8'h00);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
